// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one full-duplex WIDTH-bit exchange per accepted start, MSB first.
// SCLK half-period is CLKDIV clk cycles; CS_n can be held low across back-to-back transfers.
// All pin outputs and status flags are registered.
//
// Optional feature: define SPI_MASTER_LOOPBACK_EN to let loopback=1 feed the internal MOSI bit
// into the receive shifter instead of the synchronized MISO pin. Without the macro the loopback
// port is accepted but ignored.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   start    transfer request, accepted only in idle or held
//   txData   word to send, latched on accepted start
//   holdCS   keep CS_n low after this transfer (latched on start, sampled live while held)
//   loopback internal loopback select
//   busy     transfer or CS gap in progress
//   done     one-cycle pulse, rxData valid
//   rxData   last received word
//   CS_n     chip select, active low
//   SCLK     serial clock, idle low
//   MOSI     serial data out
//   MISO     serial data in (asynchronous)
module spi_master #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CLKDIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  input  logic             holdCS,
  input  logic             loopback,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData,
  output logic             CS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int unsigned DivW = $clog2(CLKDIV);
  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLKDIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StHeld, StGap} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             hold_q, hold_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             miso_s1_q, miso_s2_q;
  logic             div_end, last_bit, accept, rx_bit;

  assign div_end  = (div_q == DivLast);
  assign last_bit = (bit_q == BitLast);
  assign accept   = start && ((state_q == StIdle) || (state_q == StHeld));

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? tx_q[WIDTH-1] : miso_s2_q;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_bit          = miso_s2_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = StShiftLo;
      StShiftLo: begin
        // The low phase after the last high phase is the CS hold time, then finish.
        if (div_end) begin
          if (last_bit) state_d = hold_q ? StHeld : StGap;
          else          state_d = StShiftHi;
        end
      end
      StShiftHi: if (div_end) state_d = StShiftLo;
      StHeld: begin
        if (start)        state_d = StShiftLo;
        else if (!holdCS) state_d = StGap;
      end
      StGap:     if (div_end) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output and datapath next values; pins are decoded from the next state so they register
  // in step with the state.
  always_comb begin
    cs_n_d  = 1'b1;
    sclk_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    div_d   = '0;
    bit_d   = bit_q;
    tx_d    = tx_q;
    hold_d  = hold_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;

    case (state_d)
      StShiftLo: begin cs_n_d = 1'b0; busy_d = 1'b1; end
      StShiftHi: begin cs_n_d = 1'b0; busy_d = 1'b1; sclk_d = 1'b1; end
      StHeld:    cs_n_d = 1'b0;
      StGap:     busy_d = 1'b1;
      default:   ;
    endcase

    if (state_q inside {StShiftLo, StShiftHi, StGap}) begin
      div_d = div_end ? '0 : div_q + 1'b1;
    end

    if (accept) begin
      tx_d   = txData;
      hold_d = holdCS;
      bit_d  = '0;
    end

    // Sample on the last high cycle; shifting tx here makes MOSI advance on the first low cycle.
    if ((state_q == StShiftHi) && div_end) begin
      rx_sh_d = {rx_sh_q[WIDTH-2:0], rx_bit};
      bit_d   = bit_q + 1'b1;
      tx_d    = {tx_q[WIDTH-2:0], 1'b0};
    end

    if ((state_q == StShiftLo) && div_end && last_bit) begin
      rx_d   = rx_sh_q;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      hold_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      hold_q    <= hold_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign CS_n   = cs_n_q;
  assign SCLK   = sclk_q;
  assign MOSI   = tx_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;
  assign rxData = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (WIDTH=8, CLKDIV=4) with a behavioural mode-0 slave.
module tb_spi_master;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

`ifdef SPI_MASTER_LOOPBACK_EN
  localparam logic [7:0] LbExp = 8'h5A;
`else
  localparam logic [7:0] LbExp = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       holdCS = 1'b0;
  logic       loopback = 1'b0;
  logic       busy, done, CS_n, SCLK, MOSI;
  logic [7:0] rxData;
  logic       MISO = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_master #(.WIDTH(W), .CLKDIV(C)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .txData  (txData),
    .holdCS  (holdCS),
    .loopback(loopback),
    .busy    (busy),
    .done    (done),
    .rxData  (rxData),
    .CS_n    (CS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // Monitors
  int         rise_cnt = 0;
  int         done_cnt = 0;
  int         cs_fall_cnt = 0;
  int         cs_rise_cnt = 0;
  logic [7:0] mosi_cap = 8'h00;

  always @(posedge SCLK) begin
    rise_cnt = rise_cnt + 1;
    mosi_cap = {mosi_cap[6:0], MOSI};
  end

  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  always @(CS_n) begin
    if (CS_n === 1'b0) cs_fall_cnt = cs_fall_cnt + 1;
    else if (CS_n === 1'b1) cs_rise_cnt = cs_rise_cnt + 1;
  end

  // Mode-0 slave: MSB out on CS fall, next bit on each SCLK fall, reload after 8 bits.
  logic [7:0] slave_word = 8'h00;
  logic [7:0] sl_sh = 8'h00;
  int         sl_cnt = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;

  always @(CS_n, SCLK) begin
    if (prev_cs === 1'b1 && CS_n === 1'b0) begin
      sl_sh  = slave_word;
      sl_cnt = 0;
    end else if (CS_n === 1'b0 && prev_sclk === 1'b1 && SCLK === 1'b0) begin
      sl_cnt = sl_cnt + 1;
      if (sl_cnt == 8) begin
        sl_sh  = slave_word;
        sl_cnt = 0;
      end else begin
        sl_sh = {sl_sh[6:0], 1'b0};
      end
    end
    MISO      = sl_sh[7];
    prev_cs   = CS_n;
    prev_sclk = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int r0, d0, f0, u0;

  initial begin
    // Power-on reset
    cyc(3);
    chk("rst_cs_n", CS_n, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rxData, 0);

    // Single transfer, start in the first cycle after reset release
    rst = 1'b0; start = 1'b1; txData = 8'hA5; holdCS = 1'b0; slave_word = 8'h3C;
    r0 = rise_cnt; d0 = done_cnt;
    cyc(1); start = 1'b0;
    chk("t1_cs_fall", CS_n, 0);
    chk("t1_busy", busy, 1);
    chk("t1_mosi_msb", MOSI, 1);
    chk("t1_sclk_lo", SCLK, 0);
    cyc(3);  chk("t1_sclk_c4", SCLK, 0);
    cyc(1);  chk("t1_sclk_c5", SCLK, 1);
    cyc(63); chk("t1_done_c68", done, 0);
    chk("t1_cs_c68", CS_n, 0);
    cyc(1);  chk("t1_done_c69", done, 1);
    chk("t1_rx", rxData, 8'h3C);
    chk("t1_cs_c69", CS_n, 1);
    chk("t1_busy_c69", busy, 1);
    cyc(1);  chk("t1_done_c70", done, 0);
    cyc(2);  chk("t1_busy_c72", busy, 1);
    cyc(1);  chk("t1_busy_c73", busy, 0);
    chk("t1_rises", rise_cnt - r0, 8);
    chk("t1_mosi_bits", mosi_cap, 8'hA5);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // Burst with CS held between words
    start = 1'b1; txData = 8'h01; holdCS = 1'b1; slave_word = 8'hC3;
    r0 = rise_cnt; d0 = done_cnt; f0 = cs_fall_cnt; u0 = cs_rise_cnt;
    cyc(1); start = 1'b0; slave_word = 8'h5A;
    cyc(68);
    chk("t2_done1", done, 1);
    chk("t2_rx1", rxData, 8'hC3);
    chk("t2_cs_held", CS_n, 0);
    chk("t2_busy_held", busy, 0);
    start = 1'b1; txData = 8'h80; holdCS = 1'b0;
    cyc(1); start = 1'b0;
    chk("t2_cs2", CS_n, 0);
    chk("t2_busy2", busy, 1);
    chk("t2_mosi2", MOSI, 1);
    cyc(68);
    chk("t2_done2", done, 1);
    chk("t2_rx2", rxData, 8'h5A);
    chk("t2_cs_rise", CS_n, 1);
    cyc(5);
    chk("t2_idle", busy, 0);
    chk("t2_rises", rise_cnt - r0, 16);
    chk("t2_mosi_bits", mosi_cap, 8'h80);
    chk("t2_done_cnt", done_cnt - d0, 2);
    chk("t2_cs_falls", cs_fall_cnt - f0, 1);
    chk("t2_cs_rises", cs_rise_cnt - u0, 1);

    // HELD release without a new start
    start = 1'b1; txData = 8'h33; holdCS = 1'b1; slave_word = 8'h0F;
    cyc(1); start = 1'b0;
    cyc(68);
    chk("t3_done", done, 1);
    chk("t3_rx", rxData, 8'h0F);
    cyc(2);
    chk("t3_cs_held", CS_n, 0);
    chk("t3_busy_held", busy, 0);
    holdCS = 1'b0;
    cyc(1);
    chk("t3_cs_gap", CS_n, 1);
    chk("t3_busy_gap", busy, 1);
    cyc(3); chk("t3_busy_gap_end", busy, 1);
    cyc(1); chk("t3_idle", busy, 0);

    // Start ignored mid-transfer and during the gap
    start = 1'b1; txData = 8'h00; holdCS = 1'b0; slave_word = 8'h96;
    r0 = rise_cnt;
    cyc(1);  start = 1'b0;
    cyc(19); start = 1'b1; txData = 8'hFF;
    cyc(1);  start = 1'b0;
    cyc(48);
    chk("t4_done", done, 1);
    chk("t4_rx", rxData, 8'h96);
    cyc(1);  start = 1'b1;
    cyc(1);  start = 1'b0;
    cyc(2);
    chk("t4_busy_c73", busy, 0);
    chk("t4_cs_c73", CS_n, 1);
    cyc(10);
    chk("t4_cs_late", CS_n, 1);
    chk("t4_sclk_late", SCLK, 0);
    chk("t4_rises", rise_cnt - r0, 8);
    chk("t4_mosi_bits", mosi_cap, 8'h00);

    // Reset during bit 3 with random input activity
    start = 1'b1; txData = 8'hC3; holdCS = 1'b0; slave_word = 8'hFF;
    r0 = rise_cnt; d0 = done_cnt;
    cyc(1); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      start    = 1'($urandom);
      txData   = 8'($urandom);
      holdCS   = 1'($urandom);
      loopback = 1'($urandom);
    end
    cyc(1);
    rst = 1'b1; start = 1'b0; holdCS = 1'b0; loopback = 1'b0;
    cyc(1);
    chk("t5_cs_n", CS_n, 1);
    chk("t5_sclk", SCLK, 0);
    chk("t5_mosi", MOSI, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_rx", rxData, 0);
    cyc(1);
    chk("t5_rises", rise_cnt - r0, 3);
    chk("t5_no_done", done_cnt - d0, 0);

    // Loopback transfer accepted right after reset release, slave returns zeros
    rst = 1'b0; start = 1'b1; txData = 8'h5A; loopback = 1'b1; holdCS = 1'b0;
    slave_word = 8'h00;
    cyc(1); start = 1'b0;
    chk("t6_cs_fall", CS_n, 0);
    cyc(68);
    chk("t6_done", done, 1);
    chk("t6_rx", rxData, LbExp);
    cyc(5);
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
